// File: rtl/inv44_pkg.sv
// Shared types and constants for the 4x4 inverse scaling stage.
package inv44_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSeed,
    StNrMul1,
    StNrSub,
    StNrMul2,
    StStream,
    StDone
  } inv44_state_e;

  localparam logic [31:0] RECIP_MAGIC = 32'h7EF311C3;
  localparam logic [31:0] FP_TWO      = 32'h40000000;
  localparam int unsigned N_ELEM      = 16;
  localparam int unsigned EXP_MSB     = 30;
  localparam int unsigned EXP_LSB     = 23;

  // Zero, denormal, infinite or NaN determinants have no usable reciprocal.
  function automatic logic is_singular(logic [31:0] d, logic z);
    return z | (d[EXP_MSB:EXP_LSB] == 8'h00) | (d[EXP_MSB:EXP_LSB] == 8'hFF);
  endfunction

endpackage

// File: rtl/Addition_Subtraction.sv
// Combinational float32 adder/subtractor (sub=1 gives a-b), RNE, denormals flushed to zero.
module Addition_Subtraction (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] y
);
  logic [31:0] bb, x, z;
  logic [7:0]  d;
  logic [26:0] mx, mz, mzs, mask;
  logic [27:0] s;
  logic [9:0]  e;
  logic [23:0] r;

  always_comb begin
    bb = {b[31] ^ sub, b[30:0]};
    if (a[30:0] >= bb[30:0]) begin
      x = a;
      z = bb;
    end else begin
      x = bb;
      z = a;
    end
    mx   = (x[30:23] == 8'd0) ? 27'd0 : {1'b1, x[22:0], 3'b000};
    mz   = (z[30:23] == 8'd0) ? 27'd0 : {1'b1, z[22:0], 3'b000};
    d    = x[30:23] - z[30:23];
    mask = ~(27'h7FF_FFFF << d);
    mzs  = (mz >> d) | {26'd0, |(mz & mask)};
    s    = (x[31] ^ z[31]) ? {1'b0, mx} - {1'b0, mzs} : {1'b0, mx} + {1'b0, mzs};
    e    = {2'b00, x[30:23]};
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end
    for (int i = 0; i < 26; i++) begin
      if (!s[26] && e > 10'd1) begin
        s = s << 1;
        e = e - 10'd1;
      end
    end
    r = {1'b0, s[25:3]} + {23'd0, s[2] & ((|s[1:0]) | s[3])};
    if (r[23]) e = e + 10'd1;
    y = {x[31], e[7:0], r[22:0]};
    if (!s[26]) y = 32'd0;
    else if (e >= 10'd255) y = {x[31], 8'hFF, 23'd0};
  end

endmodule

// File: rtl/Mul.sv
// Combinational float32 multiplier, round-to-nearest-even, denormals flushed to zero.
module Mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [47:0] p;
  logic [9:0]  e;
  logic [22:0] f;
  logic [23:0] r;
  logic        g, st, sgn;

  always_comb begin
    sgn = a[31] ^ b[31];
    p   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e   = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) begin
      f  = p[46:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'd1;
    end else begin
      f  = p[45:23];
      g  = p[22];
      st = |p[21:0];
    end
    r = {1'b0, f} + {23'd0, g & (st | f[0])};
    if (r[23]) e = e + 10'd1;
    y = {sgn, e[7:0], r[22:0]};
    // e[9] marks a negative biased exponent (underflow).
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e[9] || e == 10'd0) y = {sgn, 31'd0};
    else if (e >= 10'd255) y = {sgn, 8'hFF, 23'd0};
  end

endmodule

// File: rtl/inv44_recip.sv
// Reciprocal engine: magic-constant seed then NR_ITER Newton-Raphson steps on one Mul/Add pair.
module inv44_recip
  import inv44_pkg::*;
#(
  parameter int unsigned NR_ITER = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] det,
  output logic        busy,
  output logic [31:0] recip
);
  inv44_state_e state_q, state_d;
  logic [1:0]   iter_q;
  logic [31:0]  det_q, x_q, mul_q, add_q, mul_y, add_y, mul_b, seed;
  logic         last_iter;

  assign last_iter = (iter_q == 2'(NR_ITER - 1));
  assign seed      = RECIP_MAGIC - {1'b0, det_q[30:0]};
  assign mul_b     = (state_q == StNrMul2) ? add_q : det_q;

  Mul u_mul (
    .a (x_q),
    .b (mul_b),
    .y (mul_y)
  );

  Addition_Subtraction u_add (
    .a   (FP_TWO),
    .b   (mul_q),
    .sub (1'b1),
    .y   (add_y)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StSeed;
      StSeed:   state_d = StNrMul1;
      StNrMul1: state_d = StNrSub;
      StNrSub:  state_d = StNrMul2;
      StNrMul2: state_d = last_iter ? StIdle : StNrMul1;
      default:  state_d = StIdle;
    endcase
  end

  // Drops during the final update so the consumer can move on the same edge x settles.
  assign busy  = (state_q != StIdle) && !((state_q == StNrMul2) && last_iter);
  assign recip = x_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      iter_q  <= 2'd0;
      det_q   <= 32'd0;
      x_q     <= 32'd0;
      mul_q   <= 32'd0;
      add_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      mul_q   <= mul_y;
      add_q   <= add_y;
      if (start && state_q == StIdle) det_q <= det;
      if (state_q == StSeed) begin
        x_q    <= {det_q[31], seed[30:0]};
        iter_q <= 2'd0;
      end
      if (state_q == StNrMul2) begin
        x_q    <= mul_y;
        iter_q <= iter_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/inv_scale_44.sv
// Scales 16 adjugate elements by 1/det to form the 4x4 inverse.
// INV44_SINGULAR_PASS_EN: singular matrices stream adjugate elements through unscaled.
module inv_scale_44
  import inv44_pkg::*;
#(
  parameter int unsigned NR_ITER = 3,
  parameter int unsigned N_ELEM  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] det,
  input  logic        det_zero,
  input  logic        det_valid,
  output logic        det_ready,
  input  logic [31:0] adj_data,
  input  logic        adj_valid,
  output logic        adj_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        singular,
  output logic        done
);
`ifdef INV44_SINGULAR_PASS_EN
  localparam bit PassEn = 1'b1;
`else
  localparam bit PassEn = 1'b0;
`endif

  inv44_state_e state_q, state_d;
  logic         sing_q, last_q, out_valid_q;
  logic [3:0]   cnt_q, out_idx_q;
  logic [31:0]  out_data_q, recip, scaled;
  logic         det_acc, det_sing, adj_acc, out_hs, cnt_last, recip_busy;

  assign det_sing = is_singular(det, det_zero);
  assign det_acc  = det_valid & det_ready;
  assign adj_acc  = adj_valid & adj_ready;
  assign out_hs   = out_valid_q & out_ready;
  assign cnt_last = (cnt_q == 4'(N_ELEM - 1));

  inv44_recip #(
    .NR_ITER (NR_ITER)
  ) u_recip (
    .clk   (clk),
    .rst_n (rst_n),
    .start (det_acc & ~det_sing),
    .det   (det),
    .busy  (recip_busy),
    .recip (recip)
  );

  Mul u_scale (
    .a (adj_data),
    .b (recip),
    .y (scaled)
  );

  always_comb begin
    state_d   = state_q;
    det_ready = rst_n & (state_q == StIdle);
    adj_ready = (state_q == StStream) & ~last_q & (~out_valid_q | out_ready);
    done      = (state_q == StDone);
    unique case (state_q)
      StIdle:   if (det_acc) state_d = det_sing ? StStream : StSeed;
      StSeed:   if (!recip_busy) state_d = StStream;
      StStream: begin
        // Without pass-through a singular matrix ends on the last accept, not a handshake.
        if (!PassEn && sing_q) begin
          if (adj_acc && cnt_last) state_d = StDone;
        end else if (last_q && out_hs) begin
          state_d = StDone;
        end
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sing_q      <= 1'b0;
      last_q      <= 1'b0;
      cnt_q       <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_idx_q   <= 4'd0;
    end else begin
      if (det_acc) begin
        sing_q <= det_sing;
        last_q <= 1'b0;
        cnt_q  <= 4'd0;
      end
      if (state_q == StDone) sing_q <= 1'b0;
      if (adj_acc) begin
        cnt_q <= cnt_q + 4'd1;
        if (cnt_last) last_q <= 1'b1;
        if (PassEn || !sing_q) begin
          out_valid_q <= 1'b1;
          out_data_q  <= (PassEn && sing_q) ? adj_data : scaled;
          out_idx_q   <= cnt_q;
        end
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign singular  = sing_q;

endmodule

// File: tb/tb_inv_scale_44.sv
// Directed bench for inv_scale_44: reciprocal scaling, latency, backpressure, singular paths, reset.
module tb_inv_scale_44;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] det;
  logic        det_zero, det_valid, det_ready;
  logic [31:0] adj_data;
  logic        adj_valid, adj_ready;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        out_valid, out_ready, singular, done;

  int checks = 0;
  int failures = 0;

  logic [31:0] adj_tab [16];
  logic [31:0] got_d [16];
  logic [3:0]  got_i [16];
  int          got_n, done_gap;
  bit          stall_bad, ready_in_stall, sing_seen, sing_at_done, dready_at_done, ov_seen;
  bit          timeout;

  inv_scale_44 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .det       (det),
    .det_zero  (det_zero),
    .det_valid (det_valid),
    .det_ready (det_ready),
    .adj_data  (adj_data),
    .adj_valid (adj_valid),
    .adj_ready (adj_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .singular  (singular),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Small non-negative integer to float32.
  function automatic logic [31:0] f32(input int v);
    int p;
    logic [31:0] m;
    if (v == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 24; i++) if ((v >> i) != 0) p = i;
    m = 32'(v - (1 << p)) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  task automatic send_det(input logic [31:0] d, input logic dz, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    det = d; det_zero = dz; det_valid = 1'b1;
    #1;
    while (!det_ready && w < 20) begin
      @(negedge clk); #1; w++;
    end
    @(posedge clk); #1;
    det_valid = 1'b0; det = 32'hDEADBEEF; det_zero = 1'b0;
    lat = 0;
    while (!adj_ready && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic run_stream(input int stall_at, input int stall_len, input int abort_at);
    int acc, cyc, stall_left, since;
    bit stall_done;
    logic [31:0] hold_d;
    logic [3:0]  hold_i;
    acc = 0; cyc = 0; stall_left = 0; since = -1; stall_done = 0;
    hold_d = 32'd0; hold_i = 4'd0;
    got_n = 0; done_gap = -1; stall_bad = 0; ready_in_stall = 0; sing_seen = 0;
    sing_at_done = 0; dready_at_done = 1; ov_seen = 0; timeout = 0;
    while (done_gap < 0) begin
      @(negedge clk);
      cyc++;
      if (cyc > 300) begin timeout = 1; break; end
      if (since >= 0) since++;
      if (done) begin
        done_gap = since; sing_at_done = singular; dready_at_done = det_ready;
        break;
      end
      if (abort_at >= 0 && acc >= abort_at) break;
      if (singular) sing_seen = 1;
      out_ready = 1'b1;
      if (stall_at >= 0 && !stall_done && stall_left == 0 && out_valid &&
          out_idx == 4'(stall_at)) begin
        stall_left = stall_len; hold_d = out_data; hold_i = out_idx;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        if (out_data !== hold_d || out_idx !== hold_i || out_valid !== 1'b1) stall_bad = 1;
        stall_left--;
        if (stall_left == 0) stall_done = 1;
      end
      adj_valid = (acc < 16);
      adj_data  = (acc < 16) ? adj_tab[acc] : 32'd0;
      #1;
      if (!out_ready && adj_ready) ready_in_stall = 1;
      if (out_valid) ov_seen = 1;
      if (out_valid && out_ready) begin
        if (got_n < 16) begin got_d[got_n] = out_data; got_i[got_n] = out_idx; end
        got_n++; since = 0;
      end
      if (adj_valid && adj_ready) begin acc++; since = 0; end
    end
    adj_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; det = 32'd0; det_zero = 0; det_valid = 0; adj_data = 32'd0;
    adj_valid = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (det_ready !== 1'b0) begin failures++; $display("FAIL rst_det_ready got=%b exp=0", det_ready); end
    checks++; if (adj_ready !== 1'b0) begin failures++; $display("FAIL rst_adj_ready got=%b exp=0", adj_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    checks++; if (out_idx !== 4'd0) begin failures++; $display("FAIL rst_out_idx got=%0d exp=0", out_idx); end
    checks++; if (singular !== 1'b0) begin failures++; $display("FAIL rst_singular got=%b exp=0", singular); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (det_ready !== 1'b1) begin failures++; $display("FAIL rst_release_det_ready got=%b exp=1", det_ready); end
  endtask

  task automatic test_scale_two();
    int lat;
    longint dd;
    for (int k = 0; k < 16; k++) adj_tab[k] = 32'h3F800000;
    send_det(32'h40000000, 1'b0, lat);
    checks++; if (lat !== 10) begin failures++; $display("FAIL two_latency got=%0d exp=10", lat); end
    run_stream(-1, 0, -1);
    checks++; if (timeout || got_n !== 16) begin failures++; $display("FAIL two_count got=%0d exp=16", got_n); end
    for (int k = 0; k < 16; k++) begin
      dd = longint'(got_d[k]) - longint'(32'h3F000000);
      checks++; if (dd > 1 || dd < -1) begin failures++; $display("FAIL two_data[%0d] got=%h exp=3f000000", k, got_d[k]); end
      checks++; if (got_i[k] !== 4'(k)) begin failures++; $display("FAIL two_idx[%0d] got=%0d exp=%0d", k, got_i[k], k); end
    end
    checks++; if (done_gap !== 1) begin failures++; $display("FAIL two_done_gap got=%0d exp=1", done_gap); end
    checks++; if (sing_seen !== 1'b0) begin failures++; $display("FAIL two_singular got=%b exp=0", sing_seen); end
    checks++; if (dready_at_done !== 1'b0) begin failures++; $display("FAIL two_ready_at_done got=%b exp=0", dready_at_done); end
    @(posedge clk); #1;
    checks++; if (det_ready !== 1'b1) begin failures++; $display("FAIL two_ready_after got=%b exp=1", det_ready); end
  endtask

  task automatic test_neg_half();
    int lat;
    longint dd;
    logic [31:0] e, t;
    for (int k = 0; k < 16; k++) adj_tab[k] = f32(k);
    send_det(32'hBF000000, 1'b0, lat);
    checks++; if (lat !== 10) begin failures++; $display("FAIL neg_latency got=%0d exp=10", lat); end
    run_stream(-1, 0, -1);
    checks++; if (timeout || got_n !== 16) begin failures++; $display("FAIL neg_count got=%0d exp=16", got_n); end
    for (int k = 0; k < 16; k++) begin
      t = f32(2 * k);
      e = {1'b1, t[30:0]};
      dd = longint'(got_d[k]) - longint'(e);
      checks++; if (dd > 1 || dd < -1) begin failures++; $display("FAIL neg_data[%0d] got=%h exp=%h", k, got_d[k], e); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    longint dd;
    logic [31:0] e;
    for (int k = 0; k < 16; k++) adj_tab[k] = f32(k);
    send_det(32'h40000000, 1'b0, lat);
    run_stream(7, 5, -1);
    checks++; if (stall_bad !== 1'b0) begin failures++; $display("FAIL bp_hold got=%b exp=0", stall_bad); end
    checks++; if (ready_in_stall !== 1'b0) begin failures++; $display("FAIL bp_adj_ready got=%b exp=0", ready_in_stall); end
    checks++; if (timeout || got_n !== 16) begin failures++; $display("FAIL bp_count got=%0d exp=16", got_n); end
    for (int k = 0; k < 16; k++) begin
      e = (k == 0) ? 32'd0 : f32(k) - 32'h00800000;
      dd = longint'(got_d[k]) - longint'(e);
      checks++; if (dd > 1 || dd < -1) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", k, got_d[k], e); end
      checks++; if (got_i[k] !== 4'(k)) begin failures++; $display("FAIL bp_idx[%0d] got=%0d exp=%0d", k, got_i[k], k); end
    end
  endtask

  task automatic test_singular(input logic [31:0] d, input logic dz);
    int lat;
    for (int k = 0; k < 16; k++) adj_tab[k] = f32(k + 1);
    send_det(d, dz, lat);
    checks++; if (lat !== 0) begin failures++; $display("FAIL sing_latency det=%h got=%0d exp=0", d, lat); end
    checks++; if (singular !== 1'b1) begin failures++; $display("FAIL sing_flag det=%h got=%b exp=1", d, singular); end
    run_stream(-1, 0, -1);
    checks++; if (timeout) begin failures++; $display("FAIL sing_timeout det=%h got=1 exp=0", d); end
`ifdef INV44_SINGULAR_PASS_EN
    checks++; if (got_n !== 16) begin failures++; $display("FAIL sing_count got=%0d exp=16", got_n); end
    for (int k = 0; k < 16; k++) begin
      checks++; if (got_d[k] !== adj_tab[k] || got_i[k] !== 4'(k)) begin
        failures++; $display("FAIL sing_pass[%0d] got=%h/%0d exp=%h/%0d", k, got_d[k], got_i[k], adj_tab[k], k);
      end
    end
`else
    checks++; if (ov_seen !== 1'b0) begin failures++; $display("FAIL sing_out_valid det=%h got=%b exp=0", d, ov_seen); end
`endif
    checks++; if (done_gap !== 1) begin failures++; $display("FAIL sing_done_gap det=%h got=%0d exp=1", d, done_gap); end
    checks++; if (sing_at_done !== 1'b1) begin failures++; $display("FAIL sing_at_done det=%h got=%b exp=1", d, sing_at_done); end
    @(posedge clk); #1;
    checks++; if (singular !== 1'b0) begin failures++; $display("FAIL sing_cleared det=%h got=%b exp=0", d, singular); end
    checks++; if (det_ready !== 1'b1) begin failures++; $display("FAIL sing_ready det=%h got=%b exp=1", d, det_ready); end
  endtask

  task automatic test_reset_midstream();
    int lat;
    longint dd;
    logic [31:0] e;
    for (int k = 0; k < 16; k++) adj_tab[k] = f32(k);
    send_det(32'h40000000, 1'b0, lat);
    run_stream(-1, 0, 6);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'd0 || out_idx !== 4'd0) begin
      failures++; $display("FAIL mid_out got=%b/%h/%0d exp=0/0/0", out_valid, out_data, out_idx);
    end
    checks++; if (det_ready !== 1'b0 || adj_ready !== 1'b0) begin
      failures++; $display("FAIL mid_ready got=%b/%b exp=0/0", det_ready, adj_ready);
    end
    checks++; if (singular !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL mid_flags got=%b/%b exp=0/0", singular, done);
    end
    @(negedge clk); rst_n = 1'b1;
    send_det(32'h40800000, 1'b0, lat);
    checks++; if (lat !== 10) begin failures++; $display("FAIL mid_latency got=%0d exp=10", lat); end
    run_stream(-1, 0, -1);
    checks++; if (timeout || got_n !== 16) begin failures++; $display("FAIL mid_count got=%0d exp=16", got_n); end
    for (int k = 0; k < 16; k++) begin
      e = (k == 0) ? 32'd0 : f32(k) - 32'h01000000;
      dd = longint'(got_d[k]) - longint'(e);
      checks++; if (dd > 1 || dd < -1 || got_i[k] !== 4'(k)) begin
        failures++; $display("FAIL mid_data[%0d] got=%h/%0d exp=%h/%0d", k, got_d[k], got_i[k], e, k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scale_two();
    test_neg_half();
    test_backpressure();
    test_singular(32'h40000000, 1'b1);
    test_singular(32'h7F800000, 1'b0);
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
